// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer owning the HI/LO registers.
// Runs a WIDTH-step shift-add multiply or a restoring divide on operand
// magnitudes, then applies a one-cycle sign fix before the result lands in HI/LO.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start, op        issue request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b             rs / rt operands
//   mthi, mtlo       write wdata to HI / LO (only while accepting)
//   wdata            move-to data
//   busy             high while an operation occupies CALC or FIX
//   done             one-cycle pulse, HI/LO hold the new result in that cycle
//   div0             pulses with done when a divide had a zero divisor
//   hi, lo           HI / LO registers
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Registered state
    logic [1:0]       r_state;
    logic             r_is_div;
    logic             r_sa;
    logic             r_sb;
    logic [CW-1:0]    r_cnt;
    logic [W2-1:0]    r_acc;    // mul: {upper, multiplier}; div: {rem, quo}
    logic [WIDTH-1:0] r_opnd;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;

    // Next-state values
    logic [1:0]       w_state_nxt;
    logic             w_is_div_nxt;
    logic             w_sa_nxt;
    logic             w_sb_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [W2-1:0]    w_acc_nxt;
    logic [WIDTH-1:0] w_opnd_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_div0_nxt;

    // Operand conditioning at issue: signed ops work on magnitudes
    logic             w_sgn_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;

    assign w_sgn_op = ~op[0];
    assign w_a_neg  = w_sgn_op & a[WIDTH-1];
    assign w_b_neg  = w_sgn_op & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_b_zero = (b == '0);

    // One shift-add multiply step; carry out of the upper add is kept
    logic [WIDTH:0]   w_mul_sum;
    logic [W2-1:0]    w_mul_step;

    assign w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[W2-1:1]};

    // One restoring divide step; shifted remainder needs WIDTH+1 bits
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [W2-1:0]    w_div_step;

    assign w_rem_sh   = r_acc[W2-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_step = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {r_acc[W2-2:0], 1'b0};

    // Sign correction; flags are zero for unsigned ops so no op check needed
    logic [W2-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_prod_fix = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo_fix  = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_sa ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];

    // Next-state and datapath update
    always_comb begin
        w_state_nxt  = r_state;
        w_is_div_nxt = r_is_div;
        w_sa_nxt     = r_sa;
        w_sb_nxt     = r_sb;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_opnd_nxt   = r_opnd;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_done_nxt   = 1'b0;
        w_div0_nxt   = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (mthi) w_hi_nxt = wdata;
                if (mtlo) w_lo_nxt = wdata;
                if (start) begin
                    if (op[1] && w_b_zero) begin
                        // divide by zero completes immediately, HI/LO untouched
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_div0_nxt  = 1'b1;
                    end else begin
                        w_state_nxt  = S_CALC;
                        w_is_div_nxt = op[1];
                        w_sa_nxt     = w_a_neg;
                        w_sb_nxt     = w_b_neg;
                        w_cnt_nxt    = '0;
                        if (op[1]) begin
                            w_acc_nxt  = {{WIDTH{1'b0}}, w_a_mag};
                            w_opnd_nxt = w_b_mag;
                        end else begin
                            w_acc_nxt  = {{WIDTH{1'b0}}, w_b_mag};
                            w_opnd_nxt = w_a_mag;
                        end
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                w_acc_nxt = r_is_div ? w_div_step : w_mul_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                if (r_is_div) begin
                    w_hi_nxt = w_rem_fix;
                    w_lo_nxt = w_quo_fix;
                end else begin
                    w_hi_nxt = w_prod_fix[W2-1:WIDTH];
                    w_lo_nxt = w_prod_fix[WIDTH-1:0];
                end
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_is_div <= w_is_div_nxt;
            r_sa     <= w_sa_nxt;
            r_sb     <= w_sb_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_opnd   <= w_opnd_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_div0   <= w_div0_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign div0 = r_div0;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: scenario tasks with inline checks plus a
// scoreboard that compares every done pulse against a queued expectation.
module tb_muldiv_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    // Behavioural reference using native arithmetic (nonzero divisor only)
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sp;
        logic [63:0] up;
        sx = 64'($signed(x));
        sy = 64'($signed(y));
        e.div0 = 1'b0;
        case (o)
            2'b00: begin sp = sx * sy; e.hi = sp[63:32]; e.lo = sp[31:0]; end
            2'b01: begin up = {32'd0, x} * {32'd0, y}; e.hi = up[63:32]; e.lo = up[31:0]; end
            2'b10: begin sp = sx / sy; e.lo = sp[31:0]; sp = sx % sy; e.hi = sp[31:0]; end
            default: begin e.lo = x / y; e.hi = x % y; end
        endcase
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done hi=%h lo=%h div0=%b", hi, lo, div0);
            end else begin
                mon_e = sb_q.pop_front();
                if ({hi, lo, div0} !== {mon_e.hi, mon_e.lo, mon_e.div0}) begin
                    errors++;
                    $display("FAIL sb_result got hi=%h lo=%h div0=%b want hi=%h lo=%h div0=%b",
                             hi, lo, div0, mon_e.hi, mon_e.lo, mon_e.div0);
                end
            end
        end
    end

    // Drive a one-cycle start at a negedge; returns at the negedge of cycle 1
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        start = 1'b1; op = o; a = x; b = y;
        if (push) sb_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0; op = 2'b00; a = '0; b = '0;
    endtask

    // Advance until done; lat is the cycle index of done (-1 on timeout)
    task automatic wait_done(input int lat0, output int lat, output int nbusy);
        lat = lat0;
        nbusy = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        int lat, nb;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, div0} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {busy, done, div0});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo});
        end
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(1, lat, nb);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", lat); end
        checks++;
        if (nb !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", nb); end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL multu_max got %h want fffffffe00000001", {hi, lo});
        end
    endtask

    task automatic test_mult();
        logic [W-1:0] ta[2] = '{32'hFFFF_FFFD, 32'h8000_0000};
        logic [W-1:0] tb[2] = '{32'd7, 32'h8000_0000};
        logic [63:0]  te[2] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000};
        int lat, nb;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            issue(2'b00, ta[i], tb[i], 1'b1);
            wait_done(1, lat, nb);
            checks++;
            if (lat !== 34) begin errors++; $display("FAIL mult_latency[%0d] got %0d want 34", i, lat); end
            checks++;
            if ({hi, lo} !== te[i]) begin
                errors++; $display("FAIL mult[%0d] got %h want %h", i, {hi, lo}, te[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [1:0]   to[3] = '{2'b10, 2'b11, 2'b10};
        logic [W-1:0] ta[3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [W-1:0] tb[3] = '{32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [63:0]  te[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003, 64'h0000_0000_8000_0000};
        int lat, nb;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(to[i], ta[i], tb[i], 1'b1);
            wait_done(1, lat, nb);
            checks++;
            if (lat !== 34) begin errors++; $display("FAIL div_latency[%0d] got %0d want 34", i, lat); end
            checks++;
            if ({hi, lo} !== te[i]) begin
                errors++; $display("FAIL div[%0d] got %h want %h", i, {hi, lo}, te[i]);
            end
        end
    endtask

    task automatic test_div0();
        int lat, nb;
        exp_t e;
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        mtlo = 1'b0; wdata = '0;
        e.hi = 32'h1234; e.lo = 32'h5678; e.div0 = 1'b1;
        sb_q.push_back(e);
        issue(2'b10, 32'd5, 32'd0, 1'b0);
        wait_done(1, lat, nb);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d want 1", lat); end
        checks++;
        if (nb !== 0) begin errors++; $display("FAIL div0_busy got %0d want 0", nb); end
        checks++;
        if ({hi, lo, div0} !== {32'h1234, 32'h5678, 1'b1}) begin
            errors++; $display("FAIL div0_result got hi=%h lo=%h div0=%b want hi=1234 lo=5678 div0=1", hi, lo, div0);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        @(negedge clk);
        issue(2'b01, 32'd2, 32'd3, 1'b1);
        repeat (3) @(negedge clk);
        // Move and second start during CALC must both be dropped
        mthi = 1'b1; wdata = 32'hAAAA; start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd7;
        @(negedge clk);
        mthi = 1'b0; wdata = '0; start = 1'b0; a = '0; b = '0;
        checks++;
        if (hi !== 32'h1234) begin errors++; $display("FAIL busy_mthi got hi=%h want 00001234", hi); end
        wait_done(5, lat, nb);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL b2b_first_latency got %0d want 34", lat); end
        checks++;
        if ({hi, lo} !== 64'h0000_0000_0000_0006) begin
            errors++; $display("FAIL b2b_first got %h want 6", {hi, lo});
        end
        // Issue in the DONE cycle
        issue(2'b11, 32'd10, 32'd3, 1'b1);
        wait_done(1, lat, nb);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency got %0d want 34", lat); end
        checks++;
        if ({hi, lo} !== 64'h0000_0001_0000_0003) begin
            errors++; $display("FAIL b2b_second got %h want 0000000100000003", {hi, lo});
        end
    endtask

    task automatic test_reset_mid();
        int lat, nb;
        bit seen;
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL midreset_flags got %b want 00", {busy, done});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++; $display("FAIL midreset_hilo got %h want 0", {hi, lo});
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midreset_activity got %b want 0", seen); end
        issue(2'b01, 32'd4, 32'd5, 1'b1);
        wait_done(1, lat, nb);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL post_reset_latency got %0d want 34", lat); end
        checks++;
        if ({hi, lo} !== 64'd20) begin
            errors++; $display("FAIL post_reset_multu got %h want 20", {hi, lo});
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() !== 0) begin
            errors++; $display("FAIL sb_leftover got %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
